// File: rtl/vga_timing_gen_if.sv
// Raster timing bus: frame-buffer ready in, raster position, strobes and frame count out.
// The generator side is the master; the output controller and debug logic sit on the slave side.
interface vga_timing_gen_if;
  logic        iREADY;
  logic [15:0] oH_Cont;
  logic [15:0] oV_Cont;
  logic        oLINE_START;
  logic        oFRAME_START;
  logic        oACTIVE;
  logic        oRUNNING;
  logic [15:0] oFRAME_CNT;

  modport master (
    input  iREADY,
    output oH_Cont,
    output oV_Cont,
    output oLINE_START,
    output oFRAME_START,
    output oACTIVE,
    output oRUNNING,
    output oFRAME_CNT
  );

  modport slave (
    output iREADY,
    input  oH_Cont,
    input  oV_Cont,
    input  oLINE_START,
    input  oFRAME_START,
    input  oACTIVE,
    input  oRUNNING,
    input  oFRAME_CNT
  );
endinterface

// File: rtl/vga_timing_gen.sv
// Free-running VGA raster counters gated by frame-buffer ready; start/stop only on frame boundaries.
// One cycle from iREADY to frame start; iREADY low lets the current frame drain, then parks in IDLE.
module vga_timing_gen #(
  parameter int H_SYNC_FRONT = 16,
  parameter int H_SYNC_CYC   = 96,
  parameter int H_SYNC_BACK  = 48,
  parameter int H_SYNC_ACT   = 640,
  parameter int V_SYNC_FRONT = 10,
  parameter int V_SYNC_CYC   = 2,
  parameter int V_SYNC_BACK  = 33,
  parameter int V_SYNC_ACT   = 480
) (
  input  logic              iCLK,
  input  logic              iRST_N,
  vga_timing_gen_if.master  bus
);

  localparam int H_BLANK      = H_SYNC_FRONT + H_SYNC_CYC + H_SYNC_BACK;
  localparam int H_SYNC_TOTAL = H_BLANK + H_SYNC_ACT;
  localparam int V_BLANK      = V_SYNC_FRONT + V_SYNC_CYC + V_SYNC_BACK;
  localparam int V_SYNC_TOTAL = V_BLANK + V_SYNC_ACT;

  localparam logic [15:0] H_LAST  = 16'(H_SYNC_TOTAL - 1);
  localparam logic [15:0] V_LAST  = 16'(V_SYNC_TOTAL - 1);
  localparam logic [15:0] H_BL16  = 16'(H_BLANK);
  localparam logic [15:0] V_BL16  = 16'(V_BLANK);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [15:0] r_h_cont;
  logic [15:0] r_v_cont;
  logic [15:0] r_frame_cnt;
  logic [15:0] w_h_nxt;
  logic [15:0] w_v_nxt;
  logic [15:0] w_frame_cnt_nxt;

  logic        w_h_last;
  logic        w_v_last;
  logic        w_frame_end;
  logic        w_running;

  assign w_h_last    = (r_h_cont == H_LAST);
  assign w_v_last    = (r_v_cont == V_LAST);
  assign w_frame_end = w_h_last && w_v_last;
  assign w_running   = (r_state != ST_IDLE);

  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      r_state     <= ST_IDLE;
      r_h_cont    <= 16'd0;
      r_v_cont    <= 16'd0;
      r_frame_cnt <= 16'd0;
    end else begin
      r_state     <= w_state_nxt;
      r_h_cont    <= w_h_nxt;
      r_v_cont    <= w_v_nxt;
      r_frame_cnt <= w_frame_cnt_nxt;
    end
  end

  // RUN and DRAIN count identically; they differ only in what the ready level means.
  always_comb begin
    w_state_nxt     = r_state;
    w_h_nxt         = r_h_cont;
    w_v_nxt         = r_v_cont;
    w_frame_cnt_nxt = r_frame_cnt;
    case (r_state)
      ST_IDLE: begin
        w_h_nxt = 16'd0;
        w_v_nxt = 16'd0;
        if (bus.iREADY) begin
          w_state_nxt = ST_RUN;
        end
      end
      ST_RUN, ST_DRAIN: begin
        if (w_h_last) begin
          w_h_nxt = 16'd0;
          w_v_nxt = w_v_last ? 16'd0 : r_v_cont + 16'd1;
        end else begin
          w_h_nxt = r_h_cont + 16'd1;
        end
        if (w_frame_end) begin
          w_frame_cnt_nxt = r_frame_cnt + 16'd1;
          w_state_nxt     = bus.iREADY ? ST_RUN : ST_IDLE;
        end else begin
          w_state_nxt     = bus.iREADY ? ST_RUN : ST_DRAIN;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_h_nxt     = 16'd0;
        w_v_nxt     = 16'd0;
      end
    endcase
  end

  assign bus.oH_Cont      = r_h_cont;
  assign bus.oV_Cont      = r_v_cont;
  assign bus.oFRAME_CNT   = r_frame_cnt;
  assign bus.oRUNNING     = w_running;
  assign bus.oLINE_START  = w_running && (r_h_cont == 16'd0);
  assign bus.oFRAME_START = w_running && (r_h_cont == 16'd0) && (r_v_cont == 16'd0);
  assign bus.oACTIVE      = w_running && (r_h_cont >= H_BL16) && (r_v_cont >= V_BL16);

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench for vga_timing_gen on a reduced raster (16x8, blank 8x4) to keep runs short.
// Positions from the full-size plan map onto this raster: (799,524)->(15,7), (160,45)->(8,4).
module tb_vga_timing_gen;
  localparam int HF = 2, HC = 3, HB = 3, HA = 8;   // H blank 8, total 16
  localparam int VF = 1, VC = 1, VB = 2, VA = 4;   // V blank 4, total 8

  logic clk;
  logic rst_n;
  int   n_chk;
  int   n_pass;
  int   exp_cnt;
  bit   ok;

  vga_timing_gen_if bus ();

  vga_timing_gen #(
    .H_SYNC_FRONT(HF), .H_SYNC_CYC(HC), .H_SYNC_BACK(HB), .H_SYNC_ACT(HA),
    .V_SYNC_FRONT(VF), .V_SYNC_CYC(VC), .V_SYNC_BACK(VB), .V_SYNC_ACT(VA)
  ) dut (
    .iCLK   (clk),
    .iRST_N (rst_n),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [52:0] snap();
    return {bus.oH_Cont, bus.oV_Cont, bus.oFRAME_START, bus.oLINE_START,
            bus.oACTIVE, bus.oRUNNING, bus.oFRAME_CNT};
  endfunction

  function automatic logic [52:0] mk(input int h, input int v, input bit fs, input bit ls,
                                     input bit act, input bit run, input int c);
    return {16'(h), 16'(v), fs, ls, act, run, 16'(c)};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_pos(input int th, input int tv, output bit found);
    found = 1'b0;
    for (int k = 0; k < 2000; k++) begin
      if (bus.oH_Cont == 16'(th) && bus.oV_Cont == 16'(tv)) begin
        found = 1'b1;
        return;
      end
      step();
    end
  endtask

  task automatic test_reset();
    logic [52:0] want;
    rst_n = 1'b0;
    bus.iREADY = 1'b1;
    repeat (3) step();
    want = mk(0, 0, 0, 0, 0, 0, 0);
    n_chk++; if (snap() !== want) $display("FAIL reset_hold got %h want %h", snap(), want); else n_pass++;
    step();
    n_chk++; if (snap() !== want) $display("FAIL reset_no_count got %h want %h", snap(), want); else n_pass++;
    rst_n = 1'b1;
    step();
    want = mk(0, 0, 1, 1, 0, 1, 0);
    n_chk++; if (snap() !== want) $display("FAIL start_first got %h want %h", snap(), want); else n_pass++;
    step();
    want = mk(1, 0, 0, 0, 0, 1, 0);
    n_chk++; if (snap() !== want) $display("FAIL start_second got %h want %h", snap(), want); else n_pass++;
  endtask

  task automatic test_line_wrap();
    logic [52:0] want;
    wait_pos(15, 0, ok);
    if (!ok) begin n_chk++; $display("FAIL line_wait_timeout got h=%0d want 15", bus.oH_Cont); end
    want = mk(15, 0, 0, 0, 0, 1, 0);
    n_chk++; if (snap() !== want) $display("FAIL line_end got %h want %h", snap(), want); else n_pass++;
    step();
    want = mk(0, 1, 0, 1, 0, 1, 0);
    n_chk++; if (snap() !== want) $display("FAIL line_wrap got %h want %h", snap(), want); else n_pass++;
  endtask

  task automatic test_frame_wrap();
    logic [52:0] want;
    wait_pos(15, 7, ok);
    if (!ok) begin n_chk++; $display("FAIL frame_wait_timeout got v=%0d want 7", bus.oV_Cont); end
    want = mk(15, 7, 0, 0, 1, 1, 0);
    n_chk++; if (snap() !== want) $display("FAIL frame_end got %h want %h", snap(), want); else n_pass++;
    step();
    exp_cnt = 1;
    want = mk(0, 0, 1, 1, 0, 1, exp_cnt);
    n_chk++; if (snap() !== want) $display("FAIL frame_wrap got %h want %h", snap(), want); else n_pass++;
  endtask

  task automatic test_frame_period();
    int cyc;
    int act;
    logic [52:0] want;
    cyc = 0;
    act = 0;
    do begin
      act += int'(bus.oACTIVE);
      step();
      cyc++;
    end while (!bus.oFRAME_START && cyc < 1000);
    exp_cnt = 2;
    n_chk++; if (cyc !== 128) $display("FAIL frame_period got %0d want 128", cyc); else n_pass++;
    n_chk++; if (act !== 32) $display("FAIL active_cycles got %0d want 32", act); else n_pass++;
    want = mk(0, 0, 1, 1, 0, 1, exp_cnt);
    n_chk++; if (snap() !== want) $display("FAIL period_end got %h want %h", snap(), want); else n_pass++;
  endtask

  task automatic test_active_window();
    logic [52:0] want;
    wait_pos(8, 3, ok);
    if (!ok) begin n_chk++; $display("FAIL act_wait_timeout got h=%0d", bus.oH_Cont); end
    want = mk(8, 3, 0, 0, 0, 1, exp_cnt);
    n_chk++; if (snap() !== want) $display("FAIL act_v_blank got %h want %h", snap(), want); else n_pass++;
    wait_pos(7, 4, ok);
    want = mk(7, 4, 0, 0, 0, 1, exp_cnt);
    n_chk++; if (snap() !== want) $display("FAIL act_h_blank got %h want %h", snap(), want); else n_pass++;
    step();
    want = mk(8, 4, 0, 0, 1, 1, exp_cnt);
    n_chk++; if (snap() !== want) $display("FAIL act_first got %h want %h", snap(), want); else n_pass++;
    wait_pos(15, 7, ok);
    want = mk(15, 7, 0, 0, 1, 1, exp_cnt);
    n_chk++; if (snap() !== want) $display("FAIL act_last got %h want %h", snap(), want); else n_pass++;
    step();
    exp_cnt = 3;
    want = mk(0, 0, 1, 1, 0, 1, exp_cnt);
    n_chk++; if (snap() !== want) $display("FAIL act_frame_wrap got %h want %h", snap(), want); else n_pass++;
  endtask

  task automatic test_drain_idle();
    logic [52:0] want;
    wait_pos(5, 3, ok);
    if (!ok) begin n_chk++; $display("FAIL drain_wait_timeout got h=%0d", bus.oH_Cont); end
    bus.iREADY = 1'b0;
    step();
    want = mk(6, 3, 0, 0, 0, 1, exp_cnt);
    n_chk++; if (snap() !== want) $display("FAIL drain_counting got %h want %h", snap(), want); else n_pass++;
    wait_pos(15, 7, ok);
    want = mk(15, 7, 0, 0, 1, 1, exp_cnt);
    n_chk++; if (snap() !== want) $display("FAIL drain_frame_end got %h want %h", snap(), want); else n_pass++;
    step();
    exp_cnt = 4;
    want = mk(0, 0, 0, 0, 0, 0, exp_cnt);
    n_chk++; if (snap() !== want) $display("FAIL drain_idle got %h want %h", snap(), want); else n_pass++;
    step();
    n_chk++; if (snap() !== want) $display("FAIL idle_hold got %h want %h", snap(), want); else n_pass++;
    bus.iREADY = 1'b1;
    step();
    want = mk(0, 0, 1, 1, 0, 1, exp_cnt);
    n_chk++; if (snap() !== want) $display("FAIL restart got %h want %h", snap(), want); else n_pass++;
    step();
    want = mk(1, 0, 0, 0, 0, 1, exp_cnt);
    n_chk++; if (snap() !== want) $display("FAIL restart_count got %h want %h", snap(), want); else n_pass++;
  endtask

  task automatic test_drain_recovery();
    logic [52:0] want;
    bit dropped;
    dropped = 1'b0;
    wait_pos(2, 1, ok);
    if (!ok) begin n_chk++; $display("FAIL recov_wait_timeout got h=%0d", bus.oH_Cont); end
    bus.iREADY = 1'b0;
    // (2,1) to (15,7) is 109 pixel clocks; ready returns after 80 of them at (2,6)
    for (int i = 1; i <= 109; i++) begin
      step();
      if (!bus.oRUNNING) dropped = 1'b1;
      if (i == 80) begin
        want = mk(2, 6, 0, 0, 0, 1, exp_cnt);
        n_chk++; if (snap() !== want) $display("FAIL recov_mid got %h want %h", snap(), want); else n_pass++;
        bus.iREADY = 1'b1;
      end
    end
    want = mk(15, 7, 0, 0, 1, 1, exp_cnt);
    n_chk++; if (snap() !== want) $display("FAIL recov_end got %h want %h", snap(), want); else n_pass++;
    n_chk++; if (dropped !== 1'b0) $display("FAIL recov_running got dropped=%0d want 0", dropped); else n_pass++;
    step();
    exp_cnt = 5;
    want = mk(0, 0, 1, 1, 0, 1, exp_cnt);
    n_chk++; if (snap() !== want) $display("FAIL recov_wrap got %h want %h", snap(), want); else n_pass++;
  endtask

  task automatic test_ready_toggle();
    logic [52:0] want;
    bit dropped;
    dropped = 1'b0;
    for (int i = 1; i <= 127; i++) begin
      bus.iREADY = (i % 2 == 1);
      step();
      if (!bus.oRUNNING) dropped = 1'b1;
    end
    want = mk(15, 7, 0, 0, 1, 1, exp_cnt);
    n_chk++; if (snap() !== want) $display("FAIL toggle_end got %h want %h", snap(), want); else n_pass++;
    n_chk++; if (dropped !== 1'b0) $display("FAIL toggle_running got dropped=%0d want 0", dropped); else n_pass++;
    bus.iREADY = 1'b0;
    step();
    exp_cnt = 6;
    want = mk(0, 0, 0, 0, 0, 0, exp_cnt);
    n_chk++; if (snap() !== want) $display("FAIL toggle_idle got %h want %h", snap(), want); else n_pass++;
    bus.iREADY = 1'b1;
    step();
    want = mk(0, 0, 1, 1, 0, 1, exp_cnt);
    n_chk++; if (snap() !== want) $display("FAIL toggle_restart got %h want %h", snap(), want); else n_pass++;
  endtask

  task automatic test_async_reset();
    logic [52:0] want;
    wait_pos(10, 5, ok);
    if (!ok) begin n_chk++; $display("FAIL arst_wait_timeout got h=%0d", bus.oH_Cont); end
    want = mk(10, 5, 0, 0, 1, 1, exp_cnt);
    n_chk++; if (snap() !== want) $display("FAIL arst_before got %h want %h", snap(), want); else n_pass++;
    #2;
    rst_n = 1'b0;
    #1;
    want = mk(0, 0, 0, 0, 0, 0, 0);
    n_chk++; if (snap() !== want) $display("FAIL arst_immediate got %h want %h", snap(), want); else n_pass++;
    step();
    n_chk++; if (snap() !== want) $display("FAIL arst_held got %h want %h", snap(), want); else n_pass++;
    rst_n = 1'b1;
    step();
    want = mk(0, 0, 1, 1, 0, 1, 0);
    n_chk++; if (snap() !== want) $display("FAIL arst_restart got %h want %h", snap(), want); else n_pass++;
    step();
    want = mk(1, 0, 0, 0, 0, 1, 0);
    n_chk++; if (snap() !== want) $display("FAIL arst_count got %h want %h", snap(), want); else n_pass++;
  endtask

  initial begin
    n_chk   = 0;
    n_pass  = 0;
    exp_cnt = 0;
    rst_n   = 1'b0;
    bus.iREADY = 1'b0;
    test_reset();
    test_line_wrap();
    test_frame_wrap();
    test_frame_period();
    test_active_window();
    test_drain_idle();
    test_drain_recovery();
    test_ready_toggle();
    test_async_reset();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1);
  end
endmodule
